// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundles for the load/store unit: datapath request/response side and
// the word-wide data-memory side with valid/ack handshake.
interface lsu_req_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, stall, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, stall, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle RV32I load/store unit: formats stores, extracts loads, waits on
// the memory ack with a timeout, and stalls the datapath until the response.
//
// state  | meaning
// IDLE   | ready for a request; captures it and checks legality
// ACCESS | mem_req held until mem_ack or timeout
// RESP   | one-cycle resp_valid pulse, then back to IDLE
module lsu_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic      clk,
  input  logic      reset,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lane[0];
      3'b010:  bad = (lane != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Returns {byte_enables, lane-replicated data}; loads get no enables.
  function automatic logic [35:0] store_fmt(input logic we, input logic [2:0] f3,
                                            input logic [1:0] lane, input logic [31:0] wd);
    logic [35:0] r;
    r = {4'b0000, wd};
    if (we) begin
      case (f3[1:0])
        2'b00:   r = {4'b0001 << lane, {4{wd[7:0]}}};
        2'b01:   r = {(lane[1] ? 4'b1100 : 4'b0011), {2{wd[15:0]}}};
        default: r = {4'b1111, wd};
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req.req_valid) begin
            we_q            <= req.req_we;
            f3_q            <= req.req_funct3;
            addr_q          <= req.req_addr;
            {be_q, wdata_q} <= store_fmt(req.req_we, req.req_funct3, req.req_addr[1:0], req.req_wdata);
            rdata_q         <= '0;
            if (is_illegal(req.req_we, req.req_funct3, req.req_addr[1:0])) begin
              err_q <= 1'b1;
              state <= S_RESP;
            end else begin
              err_q <= 1'b0;
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // ack is checked first so it wins over a coincident timeout
          if (mem.mem_ack) begin
            rdata_q <= we_q ? 32'h0 : load_extract(mem.mem_rdata, f3_q, addr_q[1:0]);
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (TO_EN && cnt == TC_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          cnt     <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req.req_ready  = (state == S_IDLE);
  assign req.stall      = reset & (((state == S_IDLE) & req.req_valid) | (state == S_ACCESS));
  assign req.resp_valid = (state == S_RESP);
  assign req.resp_rdata = (state == S_RESP) ? rdata_q : 32'h0;
  assign req.resp_err   = (state == S_RESP) & err_q;

  assign mem.mem_req   = (state == S_ACCESS);
  assign mem.mem_we    = (state == S_ACCESS) & we_q;
  assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule
